// File: rtl/mmio_port_hub_pkg.sv
// Shared constants for the EasyCPU peripheral port hub: register offsets,
// status/control bit positions and the status byte packer.
package mmio_port_hub_pkg;

  localparam logic [3:0] REG_KDATA = 4'd0;
  localparam logic [3:0] REG_KSTAT = 4'd1;
  localparam logic [3:0] REG_LED   = 4'd2;
  localparam logic [3:0] REG_KCTRL = 4'd3;
  localparam logic [3:0] REG_TLO   = 4'd4;
  localparam logic [3:0] REG_THI   = 4'd5;

  localparam int ST_OVF   = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_EMPTY = 5;

  localparam int CT_FLUSH  = 0;
  localparam int CT_CLROVF = 7;

  // Status byte: overflow/full/empty flags above a 5-bit entry count.
  function automatic logic [7:0] status_byte(input logic ovf, input logic full,
                                             input logic empty, input logic [4:0] cnt);
    logic [7:0] s;
    s           = {3'b000, cnt};
    s[ST_OVF]   = ovf;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    return s;
  endfunction

endpackage

// File: rtl/mmio_port_hub_sync_fifo.sv
// Single-clock FIFO with registered storage, flush, and head-of-queue output.
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
// when a pop frees a slot in the same cycle. Flush beats everything.
module mmio_port_hub_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers and occupancy; flush discards everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_port_hub.sv
// EasyCPU peripheral port hub: 16-byte register window holding the keyboard
// scan-code FIFO, the LED port and a prescaled 16-bit timer with snapshot.
// Read data is combinational from i_addr; the top-level mux uses o_hit.
module mmio_port_hub
  import mmio_port_hub_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFFA0,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LED_WIDTH  = 4,
  parameter int          TIMER_DIV  = 25000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          i_addr,
  input  logic [7:0]           i_data,
  input  logic                 i_wren,
  output logic [7:0]           o_data,
  output logic                 o_hit,
  input  logic [7:0]           kbd_data,
  input  logic                 kbd_valid,
  output logic [LED_WIDTH-1:0] led,
  output logic                 irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TIMER_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = 1;
  localparam logic [15:0]   TMR_ONE  = 16'd1;

  logic [3:0]           offset;
  logic                 wr_hit;
  logic                 pop, flush, clr_ovf, snap_wr, tmr_clr, led_wr;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [7:0]           fifo_head;
  logic                 ovf_set;
  logic                 tick;

  logic                 ovf_q, ovf_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [15:0]          timer_q, timer_d;
  logic [15:0]          snap_q, snap_d;

  logic                 unused_data;

  assign o_hit   = (i_addr[15:4] == BASE_ADDR[15:4]);
  assign offset  = i_addr[3:0];
  assign wr_hit  = i_wren && o_hit;

  assign pop     = wr_hit && (offset == REG_KDATA);
  assign flush   = wr_hit && (offset == REG_KCTRL) && i_data[CT_FLUSH];
  assign clr_ovf = wr_hit && (offset == REG_KCTRL) && i_data[CT_CLROVF];
  assign led_wr  = wr_hit && (offset == REG_LED);
  assign snap_wr = wr_hit && (offset == REG_TLO);
  assign tmr_clr = wr_hit && (offset == REG_THI);

  // Data bits above the LED width have no destination.
  assign unused_data = ^i_data;

  mmio_port_hub_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (kbd_valid),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (kbd_data),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A byte is lost only when full with no freeing pop and no flush discarding it.
  assign ovf_set = kbd_valid && fifo_full && !pop && !flush;
  assign tick    = (presc_q == PRE_LAST);
  assign irq     = !fifo_empty;
  assign led     = led_q;

  // Next-state for overflow, LED, prescaler, timer and snapshot.
  always_comb begin
    ovf_d   = ovf_q;
    led_d   = led_q;
    presc_d = presc_q;
    timer_d = timer_q;
    snap_d  = snap_q;

    if (ovf_set)      ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;

    if (led_wr) led_d = i_data[LED_WIDTH-1:0];

    if (tmr_clr) begin
      presc_d = '0;
      timer_d = '0;
    end else if (tick) begin
      presc_d = '0;
      timer_d = timer_q + TMR_ONE;
    end else begin
      presc_d = presc_q + PRE_ONE;
    end

    // Captures the value before this edge's increment.
    if (snap_wr) snap_d = timer_q;
  end

  // Control/timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q   <= 1'b0;
      led_q   <= '0;
      presc_q <= '0;
      timer_q <= '0;
      snap_q  <= '0;
    end else begin
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      presc_q <= presc_d;
      timer_q <= timer_d;
      snap_q  <= snap_d;
    end
  end

  // Read mux; anything outside the window or on an unused offset reads 0.
  always_comb begin
    o_data = 8'h00;
    if (o_hit) begin
      case (offset)
        REG_KDATA: o_data = fifo_empty ? 8'h00 : fifo_head;
        REG_KSTAT: o_data = status_byte(ovf_q, fifo_full, fifo_empty, 5'(fifo_count));
        REG_LED:   o_data = 8'(led_q);
        REG_TLO:   o_data = snap_q[7:0];
        REG_THI:   o_data = snap_q[15:8];
        default:   o_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_hub.sv
// Scoreboard bench for mmio_port_hub: stimulus pushes expected values,
// a negedge monitor pops and compares against the selected DUT output.
module tb_mmio_port_hub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        wren;
  logic [7:0]  rdata;
  logic        hit;
  logic [7:0]  kd;
  logic        kv;
  logic [3:0]  led;
  logic        irq;

  logic [15:0] t_addr;
  logic [7:0]  t_wdata;
  logic        t_wren;
  logic [7:0]  t_rdata;
  logic        t_hit;
  logic [3:0]  t_led;
  logic        t_irq;

  mmio_port_hub #(.BASE_ADDR(16'hFFA0), .FIFO_DEPTH(8), .LED_WIDTH(4), .TIMER_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .i_addr(addr), .i_data(wdata), .i_wren(wren),
    .o_data(rdata), .o_hit(hit), .kbd_data(kd), .kbd_valid(kv), .led(led), .irq(irq)
  );

  mmio_port_hub #(.BASE_ADDR(16'hFFA0), .FIFO_DEPTH(8), .LED_WIDTH(4), .TIMER_DIV(1)) dut_t (
    .clk(clk), .reset_n(reset_n), .i_addr(t_addr), .i_data(t_wdata), .i_wren(t_wren),
    .o_data(t_rdata), .o_hit(t_hit), .kbd_data(8'h00), .kbd_valid(1'b0), .led(t_led), .irq(t_irq)
  );

  localparam int K_DATA  = 0;
  localparam int K_HIT   = 1;
  localparam int K_IRQ   = 2;
  localparam int K_LED   = 3;
  localparam int K_TDATA = 4;
  localparam int K_TIRQ  = 5;
  localparam int K_TLED  = 6;

  int         kind_q[$];
  logic [7:0] exp_q[$];
  string      name_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  int         mon_k;
  logic [7:0] mon_e, mon_a;
  string      mon_n;

  task automatic expect_v(input int k, input logic [7:0] e, input string nm);
    kind_q.push_back(k);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares every expectation queued during this cycle.
  always @(negedge clk) begin
    while (kind_q.size() > 0) begin
      mon_k = kind_q.pop_front();
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      case (mon_k)
        K_DATA:  mon_a = rdata;
        K_HIT:   mon_a = {7'b0, hit};
        K_IRQ:   mon_a = {7'b0, irq};
        K_LED:   mon_a = {4'b0, led};
        K_TDATA: mon_a = t_rdata;
        K_TIRQ:  mon_a = {7'b0, t_irq};
        K_TLED:  mon_a = {4'b0, t_led} | {7'b0, ~t_hit};
        default: mon_a = 8'hxx;
      endcase
      n_chk++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got %02h expected %02h", mon_n, mon_a, mon_e);
      end
    end
  end

  task automatic op(input logic [15:0] a, input logic w, input logic [7:0] d,
                    input logic v, input logic [7:0] c);
    @(posedge clk); #1;
    addr = a; wren = w; wdata = d; kv = v; kd = c;
  endtask

  task automatic rd(input logic [15:0] a);
    op(a, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    op(a, 1'b1, d, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] c);
    op(16'h0000, 1'b0, 8'h00, 1'b1, c);
  endtask

  task automatic t_op(input logic [15:0] a, input logic w);
    @(posedge clk); #1;
    t_addr = a; t_wren = w; t_wdata = 8'h00;
    addr = 16'h0000; wren = 1'b0; kv = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    addr = 16'h0000; wdata = 8'h00; wren = 1'b0; kd = 8'h00; kv = 1'b0;
    t_addr = 16'h0000; t_wdata = 8'h00; t_wren = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state; ops 1..4 after reset release.
    rd(16'hFFA1);
    expect_v(K_DATA, 8'h20, "rst_status");
    expect_v(K_HIT, 8'h01, "rst_hit");
    expect_v(K_IRQ, 8'h00, "rst_irq");
    expect_v(K_LED, 8'h00, "rst_led");
    rd(16'hFFA4); expect_v(K_DATA, 8'h00, "rst_snap_lo");
    rd(16'hFFA0); expect_v(K_DATA, 8'h00, "rst_head");
    rd(16'hFFA3); expect_v(K_DATA, 8'h00, "rst_ctrl_read");

    // Timer with TIMER_DIV=4: snapshot written on op 40 captures 40/4 = 10.
    repeat (35) rd(16'h0000);
    wr(16'hFFA4, 8'h00);
    rd(16'hFFA4); expect_v(K_DATA, 8'h0A, "snap_lo_40");
    rd(16'hFFA5); expect_v(K_DATA, 8'h00, "snap_hi_40");
    wr(16'hFFA5, 8'h00);
    wr(16'hFFA4, 8'h00);
    rd(16'hFFA4); expect_v(K_DATA, 8'h00, "snap_after_clr_lo");
    rd(16'hFFA5); expect_v(K_DATA, 8'h00, "snap_after_clr_hi");

    // Basic push / pop.
    push(8'h1C); push(8'h32); push(8'hF0);
    rd(16'hFFA1);
    expect_v(K_DATA, 8'h03, "stat_3");
    expect_v(K_IRQ, 8'h01, "irq_3");
    rd(16'hFFA0); expect_v(K_DATA, 8'h1C, "head_1c");
    wr(16'hFFA0, 8'h00); expect_v(K_DATA, 8'h1C, "head_1c_at_pop");
    rd(16'hFFA0); expect_v(K_DATA, 8'h32, "head_32");
    rd(16'hFFA1); expect_v(K_DATA, 8'h02, "stat_2");
    wr(16'hFFA3, 8'h01);
    rd(16'hFFA1);
    expect_v(K_DATA, 8'h20, "stat_flushed");
    expect_v(K_IRQ, 8'h00, "irq_flushed");

    // Overflow: nine pushes into eight entries.
    for (int i = 1; i <= 9; i++) push(8'(i));
    rd(16'hFFA1); expect_v(K_DATA, 8'hC8, "stat_ovf");
    wr(16'hFFA3, 8'h80);
    rd(16'hFFA1); expect_v(K_DATA, 8'h48, "stat_ovf_clr");
    for (int i = 1; i <= 8; i++) begin
      wr(16'hFFA0, 8'h00);
      expect_v(K_DATA, 8'(i), $sformatf("ovf_order_%0d", i));
    end
    rd(16'hFFA1); expect_v(K_DATA, 8'h20, "stat_drained");

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    op(16'hFFA0, 1'b1, 8'h00, 1'b1, 8'h18);
    expect_v(K_DATA, 8'h10, "full_pp_head");
    rd(16'hFFA1); expect_v(K_DATA, 8'h48, "full_pp_stat");
    for (int i = 1; i <= 8; i++) begin
      wr(16'hFFA0, 8'h00);
      expect_v(K_DATA, 8'(8'h10 + i), $sformatf("full_pp_order_%0d", i));
    end
    rd(16'hFFA1); expect_v(K_DATA, 8'h20, "full_pp_drained");

    // Empty FIFO with simultaneous push and pop.
    op(16'hFFA0, 1'b1, 8'h00, 1'b1, 8'h55);
    rd(16'hFFA1); expect_v(K_DATA, 8'h01, "empty_pp_stat");
    rd(16'hFFA0); expect_v(K_DATA, 8'h55, "empty_pp_head");

    // Flush together with push.
    op(16'hFFA3, 1'b1, 8'h01, 1'b1, 8'h66);
    rd(16'hFFA1); expect_v(K_DATA, 8'h20, "flush_push_stat");

    // Overflow set and clear in the same cycle.
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    op(16'hFFA3, 1'b1, 8'h80, 1'b1, 8'h99);
    rd(16'hFFA1); expect_v(K_DATA, 8'hC8, "ovf_set_wins");
    wr(16'hFFA3, 8'h81);
    rd(16'hFFA1); expect_v(K_DATA, 8'h20, "ovf_clr_flush");

    // LED port and window decode.
    wr(16'hFFA2, 8'hFF);
    rd(16'hFFA2);
    expect_v(K_DATA, 8'h0F, "led_read_ff");
    expect_v(K_LED, 8'h0F, "led_pins_ff");
    wr(16'hFFA2, 8'h5A);
    rd(16'hFFA2);
    expect_v(K_DATA, 8'h0A, "led_read_5a");
    expect_v(K_LED, 8'h0A, "led_pins_5a");
    wr(16'hFFB2, 8'h03);
    rd(16'hFFB0);
    expect_v(K_HIT, 8'h00, "hit_ffb0");
    expect_v(K_DATA, 8'h00, "data_ffb0");
    expect_v(K_LED, 8'h0A, "led_outside_write");
    rd(16'hFF9F); expect_v(K_HIT, 8'h00, "hit_ff9f");
    rd(16'hFFAF);
    expect_v(K_HIT, 8'h01, "hit_ffaf");
    expect_v(K_DATA, 8'h00, "data_ffaf");
    rd(16'hFFA6); expect_v(K_DATA, 8'h00, "data_ffa6");

    // Asynchronous reset mid-operation.
    push(8'h77);
    rd(16'hFFA1);
    expect_v(K_DATA, 8'h01, "pre_rst_stat");
    expect_v(K_IRQ, 8'h01, "pre_rst_irq");
    @(posedge clk); #1;
    reset_n = 1'b0; kv = 1'b0;
    expect_v(K_DATA, 8'h20, "midrst_stat");
    expect_v(K_IRQ, 8'h00, "midrst_irq");
    expect_v(K_LED, 8'h00, "midrst_led");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Timer with TIMER_DIV=1: every cycle is a tick. j counts ops from the clear.
    t_op(16'hFFA5, 1'b1);                                   // j=0 clear (same edge as a tick)
    t_op(16'hFFA4, 1'b1);                                   // j=1 snapshot
    t_op(16'hFFA4, 1'b0); expect_v(K_TDATA, 8'h00, "t_clr_wins_lo");
    t_op(16'hFFA5, 1'b0); expect_v(K_TDATA, 8'h00, "t_clr_wins_hi");
    expect_v(K_TIRQ, 8'h00, "t_irq");
    repeat (65532) t_op(16'h0000, 1'b0);                    // j=4..65535
    t_op(16'hFFA4, 1'b1);                                   // j=65536 captures FFFF
    t_op(16'hFFA4, 1'b0); expect_v(K_TDATA, 8'hFF, "t_ffff_lo");
    t_op(16'hFFA5, 1'b0); expect_v(K_TDATA, 8'hFF, "t_ffff_hi");
    t_op(16'hFFA4, 1'b1);                                   // j=65539 captures 0002 after wrap
    t_op(16'hFFA4, 1'b0); expect_v(K_TDATA, 8'h02, "t_wrap_lo");
    t_op(16'hFFA5, 1'b0); expect_v(K_TDATA, 8'h00, "t_wrap_hi");
    t_op(16'hFFA2, 1'b0); expect_v(K_TLED, 8'h00, "t_led");

    @(negedge clk); #1;
    if (kind_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", kind_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
